// File: rtl/spi_seq_fsm.sv
// Per-bit SPI state tracker with programmable pattern matcher,
// saturating match counter and consecutive-ones run counter.
module spi_seq_fsm #(
    parameter int STATE_W = 8,
    parameter int PAT_LEN = 8,
    parameter int CNT_W   = 16,
    localparam int LEN_W  = $clog2(PAT_LEN + 1)
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Valid,
    input  logic               i_Signal,
    input  logic               i_Clear,
    input  logic [PAT_LEN-1:0] i_Pattern,
    input  logic [LEN_W-1:0]   i_PatLen,
    output logic [STATE_W-1:0] o_State,
    output logic               o_StateValid,
    output logic               o_Match,
    output logic [CNT_W-1:0]   o_MatchCount,
    output logic [CNT_W-1:0]   o_OnesRun
);

    typedef enum logic [STATE_W-1:0] {
        IDLE    = STATE_W'(0),
        STATE_1 = STATE_W'(1),
        STATE_2 = STATE_W'(2),
        STATE_3 = STATE_W'(3)
    } state_t;

    localparam logic [LEN_W-1:0] PAT_MAX = LEN_W'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    state_t             nxt_state;
    logic               legal;
    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] new_hist;
    logic [LEN_W-1:0]   bit_cnt;
    logic [LEN_W-1:0]   new_cnt;
    logic [LEN_W-1:0]   eff_len;
    logic               pat_eq;
    logic               hit;

    generate
        if (PAT_LEN > 1) begin : g_shift
            assign new_hist = {hist[PAT_LEN-2:0], i_Signal};
        end else begin : g_single
            assign new_hist = i_Signal;
        end
    endgenerate

    always_comb begin
        nxt_state = IDLE;
        legal     = 1'b1;
        unique case (state)
            IDLE:    nxt_state = i_Signal ? STATE_1 : STATE_2;
            STATE_1: nxt_state = i_Signal ? STATE_3 : STATE_2;
            STATE_2: nxt_state = i_Signal ? STATE_1 : STATE_2;
            STATE_3: nxt_state = i_Signal ? STATE_1 : STATE_2;
            default: legal     = 1'b0;
        endcase
    end

    always_comb begin
        new_cnt = (bit_cnt == PAT_MAX) ? bit_cnt : bit_cnt + LEN_W'(1);
        eff_len = (i_PatLen > PAT_MAX) ? PAT_MAX : i_PatLen;
        pat_eq  = 1'b1;
        for (int i = 0; i < PAT_LEN; i++) begin
            if (i < int'(eff_len) && new_hist[i] != i_Pattern[i]) begin
                pat_eq = 1'b0;
            end
        end
        hit = (eff_len != '0) && (new_cnt >= eff_len) && pat_eq;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state        <= IDLE;
            hist         <= '0;
            bit_cnt      <= '0;
            o_StateValid <= 1'b0;
            o_Match      <= 1'b0;
            o_MatchCount <= '0;
            o_OnesRun    <= '0;
        end else if (i_Clear) begin
            state        <= IDLE;
            hist         <= '0;
            bit_cnt      <= '0;
            o_StateValid <= 1'b0;
            o_Match      <= 1'b0;
            o_MatchCount <= '0;
            o_OnesRun    <= '0;
        end else begin
            o_StateValid <= 1'b0;
            o_Match      <= 1'b0;
            // A corrupted state recovers to IDLE without consuming a bit
            if (!legal) begin
                state <= IDLE;
            end else if (i_Valid) begin
                state        <= nxt_state;
                hist         <= new_hist;
                bit_cnt      <= new_cnt;
                o_StateValid <= 1'b1;
                if (!i_Signal) begin
                    o_OnesRun <= '0;
                end else if (o_OnesRun != CNT_MAX) begin
                    o_OnesRun <= o_OnesRun + CNT_W'(1);
                end
                if (hit) begin
                    o_Match <= 1'b1;
                    if (o_MatchCount != CNT_MAX) begin
                        o_MatchCount <= o_MatchCount + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign o_State = state;

endmodule

// File: tb/tb_spi_seq_fsm.sv
// Scoreboard bench for spi_seq_fsm: default instance plus a
// CNT_W=4 instance sharing the same stimulus for saturation.
module tb_spi_seq_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic       sig = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] pat = '0;
    logic [3:0] plen = '0;

    logic [7:0]  st, st4;
    logic        sv, sv4, m, m4;
    logic [15:0] mc, ones;
    logic [3:0]  mc4, ones4;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  st;
        logic        m;
        logic [15:0] mc;
        logic [15:0] o16;
        logic [3:0]  o4;
    } exp_t;

    exp_t sb[$];
    bit   hq[$];
    int   m_state = 0;
    int   m_mc = 0;
    int   m_ones = 0;

    spi_seq_fsm dut (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(valid), .i_Signal(sig),
        .i_Clear(clr), .i_Pattern(pat), .i_PatLen(plen),
        .o_State(st), .o_StateValid(sv), .o_Match(m),
        .o_MatchCount(mc), .o_OnesRun(ones)
    );

    spi_seq_fsm #(.CNT_W(4)) dut4 (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(valid), .i_Signal(sig),
        .i_Clear(clr), .i_Pattern(pat), .i_PatLen(plen),
        .o_State(st4), .o_StateValid(sv4), .o_Match(m4),
        .o_MatchCount(mc4), .o_OnesRun(ones4)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        hq.delete();
        m_state = 0;
        m_mc = 0;
        m_ones = 0;
    endtask

    task automatic model_push(input bit b);
        exp_t e;
        int   l;
        bit   hit;
        case (m_state)
            0: m_state = b ? 1 : 2;
            1: m_state = b ? 3 : 2;
            default: m_state = b ? 1 : 2;
        endcase
        hq.push_back(b);
        l = (plen > 8) ? 8 : int'(plen);
        hit = (l != 0) && (hq.size() >= l);
        for (int i = 0; i < l; i++) begin
            if (hit && hq[hq.size() - 1 - i] != pat[i]) hit = 0;
        end
        if (hit && m_mc < 65535) m_mc++;
        m_ones = b ? m_ones + 1 : 0;
        e.st = 8'(m_state);
        e.m = hit;
        e.mc = 16'(m_mc);
        e.o16 = (m_ones > 65535) ? 16'hffff : 16'(m_ones);
        e.o4 = (m_ones > 15) ? 4'hf : 4'(m_ones);
        sb.push_back(e);
    endtask

    task automatic send_bit(input bit b);
        exp_t e;
        @(negedge clk);
        valid = 1'b1;
        sig = b;
        model_push(b);
        @(negedge clk);
        valid = 1'b0;
        e = sb.pop_front();
        n_chk += 6;
        if (sv !== 1'b1) begin
            n_fail++; $display("FAIL strobe got %b want 1", sv);
        end
        if (st !== e.st) begin
            n_fail++; $display("FAIL state got %0d want %0d", st, e.st);
        end
        if (m !== e.m) begin
            n_fail++; $display("FAIL match got %b want %b", m, e.m);
        end
        if (mc !== e.mc) begin
            n_fail++; $display("FAIL mcount got %0d want %0d", mc, e.mc);
        end
        if (ones !== e.o16) begin
            n_fail++; $display("FAIL ones got %0d want %0d", ones, e.o16);
        end
        if (ones4 !== e.o4) begin
            n_fail++; $display("FAIL ones4 got %0d want %0d", ones4, e.o4);
        end
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk += 6;
        if (st !== 8'd0 || st4 !== 8'd0) begin
            n_fail++; $display("FAIL rst_state got %0d want 0", st);
        end
        if (sv !== 1'b0 || sv4 !== 1'b0) begin
            n_fail++; $display("FAIL rst_strobe got %b want 0", sv);
        end
        if (m !== 1'b0) begin
            n_fail++; $display("FAIL rst_match got %b want 0", m);
        end
        if (mc !== 16'd0) begin
            n_fail++; $display("FAIL rst_mcount got %0d want 0", mc);
        end
        if (ones !== 16'd0) begin
            n_fail++; $display("FAIL rst_ones got %0d want 0", ones);
        end
        if (ones4 !== 4'd0 || mc4 !== 4'd0 || m4 !== 1'b0) begin
            n_fail++; $display("FAIL rst_cnt4 got %0d want 0", ones4);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        bit          bits [6] = '{1, 1, 1, 0, 0, 1};
        logic [7:0]  wst  [6] = '{1, 3, 1, 2, 2, 1};
        logic [15:0] won  [6] = '{1, 2, 3, 0, 0, 1};
        plen = 4'd0;
        for (int i = 0; i < 6; i++) begin
            send_bit(bits[i]);
            n_chk += 2;
            if (st !== wst[i]) begin
                n_fail++; $display("FAIL basic_st%0d got %0d want %0d", i, st, wst[i]);
            end
            if (ones !== won[i]) begin
                n_fail++; $display("FAIL basic_on%0d got %0d want %0d", i, ones, won[i]);
            end
        end
    endtask

    task automatic test_gaps();
        logic [7:0]  hs;
        logic [15:0] ho;
        send_bit(1'b0);
        hs = 8'(m_state);
        ho = 16'(m_ones);
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            n_chk += 3;
            if (sv !== 1'b0 || m !== 1'b0) begin
                n_fail++; $display("FAIL gap_strobe got %b%b want 00", sv, m);
            end
            if (st !== hs) begin
                n_fail++; $display("FAIL gap_state got %0d want %0d", st, hs);
            end
            if (ones !== ho) begin
                n_fail++; $display("FAIL gap_ones got %0d want %0d", ones, ho);
            end
        end
        send_bit(1'b1);
        n_chk++;
        if (st !== 8'd1) begin
            n_fail++; $display("FAIL gap_after got %0d want 1", st);
        end
    endtask

    task automatic test_pattern();
        bit bits [5] = '{1, 0, 1, 0, 1};
        do_clear();
        plen = 4'd3;
        pat = 8'b101;
        for (int i = 0; i < 5; i++) send_bit(bits[i]);
        n_chk++;
        if (mc !== 16'd2) begin
            n_fail++; $display("FAIL pat_count got %0d want 2", mc);
        end
        do_clear();
        plen = 4'd0;
        for (int i = 0; i < 5; i++) send_bit(bits[i]);
        n_chk++;
        if (mc !== 16'd0) begin
            n_fail++; $display("FAIL pat_off got %0d want 0", mc);
        end
    endtask

    task automatic test_short_hist();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        plen = 4'd2;
        pat = 8'b00;
        send_bit(1'b0);
        n_chk++;
        if (m !== 1'b0) begin
            n_fail++; $display("FAIL short_first got %b want 0", m);
        end
        send_bit(1'b0);
        n_chk++;
        if (m !== 1'b1) begin
            n_fail++; $display("FAIL short_second got %b want 1", m);
        end
    endtask

    task automatic test_saturate();
        do_clear();
        plen = 4'd0;
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        n_chk += 2;
        if (ones4 !== 4'd15) begin
            n_fail++; $display("FAIL sat4 got %0d want 15", ones4);
        end
        if (ones !== 16'd20) begin
            n_fail++; $display("FAIL sat16 got %0d want 20", ones);
        end
        send_bit(1'b0);
        n_chk++;
        if (ones4 !== 4'd0) begin
            n_fail++; $display("FAIL sat_zero got %0d want 0", ones4);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   bits [6] = '{1, 1, 1, 0, 1, 1};
        do_clear();
        plen = 4'd2;
        pat = 8'b11;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k > 0) begin
                e = sb.pop_front();
                n_chk += 4;
                if (sv !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_sv%0d got %b want 1", k, sv);
                end
                if (st !== e.st) begin
                    n_fail++; $display("FAIL b2b_st%0d got %0d want %0d", k, st, e.st);
                end
                if (m !== e.m) begin
                    n_fail++; $display("FAIL b2b_m%0d got %b want %b", k, m, e.m);
                end
                if (mc !== e.mc) begin
                    n_fail++; $display("FAIL b2b_mc%0d got %0d want %0d", k, mc, e.mc);
                end
            end
            if (k < 6) begin
                valid = 1'b1;
                sig = bits[k];
                model_push(bits[k]);
            end else begin
                valid = 1'b0;
            end
        end
        n_chk++;
        if (mc !== 16'd3) begin
            n_fail++; $display("FAIL b2b_total got %0d want 3", mc);
        end
    endtask

    task automatic test_clear_rst();
        do_clear();
        plen = 4'd0;
        send_bit(1'b0);
        @(negedge clk);
        clr = 1'b1;
        valid = 1'b1;
        sig = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        valid = 1'b0;
        model_reset();
        n_chk += 2;
        if (st !== 8'd0 || ones !== 16'd0) begin
            n_fail++; $display("FAIL clr_state got %0d/%0d want 0/0", st, ones);
        end
        if (sv !== 1'b0) begin
            n_fail++; $display("FAIL clr_strobe got %b want 0", sv);
        end
        send_bit(1'b1);
        send_bit(1'b1);
        #2 rst = 1'b1;
        #1;
        n_chk += 2;
        if (st !== 8'd0 || ones !== 16'd0 || sv !== 1'b0) begin
            n_fail++; $display("FAIL async_rst got %0d/%0d/%b want 0", st, ones, sv);
        end
        if (mc !== 16'd0 || m !== 1'b0) begin
            n_fail++; $display("FAIL async_cnt got %0d want 0", mc);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        send_bit(1'b1);
        n_chk++;
        if (st !== 8'd1) begin
            n_fail++; $display("FAIL post_rst got %0d want 1", st);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_pattern();
        test_short_hist();
        test_saturate();
        test_back_to_back();
        test_clear_rst();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
